// File: rtl/request_unit_fsm.sv
// Sequences instruction/data memory requests for the single-cycle MIPS datapath.
// Latency: ALU op retires on the ihit cycle; load/store retires on the dhit cycle.
// Backpressure: stalls on missing ihit/dhit with request lines held; HALT is terminal until RST.
module request_unit_fsm #(
    parameter int WAIT_LIMIT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             cu_dREN,
    input  logic             cu_dWEN,
    input  logic             cu_halt,
    output logic             imemREN,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic             pc_en,
    output logic             halt,
    output logic             timeout,
    output logic [CNT_W-1:0] retired
);

    localparam int WCNT_W = $clog2(WAIT_LIMIT + 1);
    localparam logic [WCNT_W-1:0] WAIT_MAX  = WCNT_W'(WAIT_LIMIT);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_LIMIT - 1);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DATA   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t             state;
    logic [WCNT_W-1:0]  wait_cnt;

    // PC advances on a plain fetch (no data, no halt) or when the data access completes
    always_comb begin
        pc_en = 1'b0;
        if (state == FETCH && ihit && !cu_halt && !cu_dREN && !cu_dWEN)
            pc_en = 1'b1;
        else if (state == DATA && dhit)
            pc_en = 1'b1;
    end

    // Request sequencer: fetch, optional data phase, sticky halt, data-wait watchdog
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= FETCH;
            imemREN  <= 1'b1;
            dmemREN  <= 1'b0;
            dmemWEN  <= 1'b0;
            halt     <= 1'b0;
            timeout  <= 1'b0;
            wait_cnt <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (ihit) begin
                        if (cu_halt) begin
                            // halt wins over any data decode of the same instruction
                            state   <= HALTED;
                            halt    <= 1'b1;
                            imemREN <= 1'b0;
                        end else if (cu_dREN || cu_dWEN) begin
                            // a load+store decode is treated as a store: one request only
                            state    <= DATA;
                            imemREN  <= 1'b0;
                            dmemWEN  <= cu_dWEN;
                            dmemREN  <= cu_dREN & ~cu_dWEN;
                            wait_cnt <= '0;
                        end
                    end
                end
                DATA: begin
                    if (dhit) begin
                        state    <= FETCH;
                        imemREN  <= 1'b1;
                        dmemREN  <= 1'b0;
                        dmemWEN  <= 1'b0;
                        wait_cnt <= '0;
                    end else begin
                        if (wait_cnt != WAIT_MAX)
                            wait_cnt <= wait_cnt + WCNT_W'(1);
                        // timeout stays set; the access may still complete later
                        if (wait_cnt >= WAIT_LAST)
                            timeout <= 1'b1;
                    end
                end
                HALTED: begin
                    imemREN <= 1'b0;
                    dmemREN <= 1'b0;
                    dmemWEN <= 1'b0;
                    halt    <= 1'b1;
                end
                default: begin
                    state    <= FETCH;
                    imemREN  <= 1'b1;
                    dmemREN  <= 1'b0;
                    dmemWEN  <= 1'b0;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // Retired-instruction counter: one per PC advance, wraps naturally
    always_ff @(posedge CLK) begin
        if (RST)
            retired <= '0;
        else if (pc_en)
            retired <= retired + CNT_W'(1);
    end

endmodule

// File: tb/tb_request_unit_fsm.sv
// Self-checking bench for request_unit_fsm with a transaction-level reference model.
// Latency: one check per cycle, sampled 1ns after the falling edge.
// Backpressure: ihit/dhit driven directly; random stalls, halts and resets.
module tb_request_unit_fsm;

    localparam int WL = 4;
    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          ihit = 1'b0;
    logic          dhit = 1'b0;
    logic          cu_dREN = 1'b0;
    logic          cu_dWEN = 1'b0;
    logic          cu_halt = 1'b0;
    logic          imemREN;
    logic          dmemREN;
    logic          dmemWEN;
    logic          pc_en;
    logic          halt;
    logic          timeout;
    logic [CW-1:0] retired;

    request_unit_fsm #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .cu_dREN(cu_dREN), .cu_dWEN(cu_dWEN), .cu_halt(cu_halt),
        .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .pc_en(pc_en), .halt(halt), .timeout(timeout), .retired(retired)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Reference model: an outstanding memory request (0 none, 1 read, 2 write),
    // how many cycles it has waited, whether the core has halted, and a retire tally.
    bit m_valid  = 0;
    bit m_halted = 0;
    int m_req    = 0;
    int m_waited = 0;
    bit m_to     = 0;
    int m_ret    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare every output with the model, advance the model
    task automatic cyc(input logic r, input logic i, input logic d,
                       input logic rd, input logic wr, input logic h);
        bit exp_pc;
        @(negedge CLK);
        RST = r; ihit = i; dhit = d; cu_dREN = rd; cu_dWEN = wr; cu_halt = h;
        #1;
        exp_pc = !m_halted && ((m_req == 0 && i && !h && !rd && !wr) || (m_req != 0 && d));
        if (m_valid) begin
            check("imemREN", 32'(imemREN), 32'(!m_halted && m_req == 0));
            check("dmemREN", 32'(dmemREN), 32'(m_req == 1));
            check("dmemWEN", 32'(dmemWEN), 32'(m_req == 2));
            check("halt",    32'(halt),    32'(m_halted));
            check("timeout", 32'(timeout), 32'(m_to));
            check("retired", 32'(retired), 32'(m_ret));
            if (!r)
                check("pc_en", 32'(pc_en), 32'(exp_pc));
        end
        if (r) begin
            m_halted = 0; m_req = 0; m_waited = 0; m_to = 0; m_ret = 0;
            m_valid  = 1;
        end else if (m_valid) begin
            if (exp_pc)
                m_ret = (m_ret + 1) % (1 << CW);
            if (!m_halted) begin
                if (m_req == 0) begin
                    if (i && h)
                        m_halted = 1;
                    else if (i && (rd || wr)) begin
                        m_req    = wr ? 2 : 1;
                        m_waited = 0;
                    end
                end else if (d) begin
                    m_req    = 0;
                    m_waited = 0;
                end else begin
                    m_waited++;
                    if (m_waited >= WL)
                        m_to = 1;
                end
            end
        end
    endtask

    initial begin
        // reset, then five ALU instructions
        cyc(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("alu5_retired", 32'(retired), 32'd5);

        // load with three stall cycles
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("load_retired", 32'(retired), 32'd1);

        // load+store decode behaves as a store
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 1, 0);
        cyc(0, 1, 0, 0, 0, 0);
        check("both_wen", 32'(dmemWEN), 32'd1);
        check("both_ren", 32'(dmemREN), 32'd0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // halt beats a store decode; later pulses are ignored; reset recovers
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 1);
        for (int k = 0; k < 4; k++) cyc(0, 1, 1, 1, 1, 0);
        check("halt_sticky", 32'(halt), 32'd1);
        check("halt_nowen",  32'(dmemWEN), 32'd0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("halt_cleared", 32'(halt), 32'd0);
        check("halt_imem",    32'(imemREN), 32'd1);

        // store never acknowledged -> timeout, then late dhit
        cyc(0, 1, 0, 0, 1, 0);
        for (int k = 0; k < 6; k++) cyc(0, 0, 0, 0, 0, 0);
        check("timeout_set", 32'(timeout), 32'd1);
        check("timeout_wen", 32'(dmemWEN), 32'd1);
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("timeout_kept", 32'(timeout), 32'd1);

        // reset in the middle of a load
        cyc(0, 1, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("rst_mid_ren", 32'(dmemREN), 32'd0);
        check("rst_mid_to",  32'(timeout), 32'd0);

        // 17 ALU instructions wrap a 4-bit counter to 1
        cyc(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 17; k++) cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("wrap_retired", 32'(retired), 32'd1);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            logic r, i, d, rd, wr, h;
            r  = (m_halted ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 60) == 0));
            i  = ($urandom_range(0, 3) != 0);
            d  = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 2) == 0);
            wr = ($urandom_range(0, 2) == 0);
            h  = ($urandom_range(0, 20) == 0);
            cyc(r, i, d, rd, wr, h);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
